// File: rtl/window_invoke_scheduler.sv
// Level-1 CFDF invoke scheduler: checks whether the current mode may fire and
// hands it to the level-2 firing FSM. Then it counts each firing and rotates the mode.
module window_invoke_scheduler #(
  parameter int size      = 3,
  parameter int pop_width = 6,
  parameter int cnt_width = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 invoke_in,
  input  logic [pop_width-1:0] pop_in_data,
  input  logic [pop_width-1:0] free_out_fifo,
  input  logic                 done_in,
  output logic                 start_out,
  output logic [1:0]           next_mode_out,
  output logic                 invoke_done_out,
  output logic                 fired_out,
  output logic [cnt_width-1:0] fire_count_out
);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    FIRE,
    WAIT,
    DONE
  } state_t;

  localparam logic [1:0] MODE_SETUP  = 2'b00;
  localparam logic [1:0] MODE_COMP   = 2'b01;
  localparam logic [1:0] MODE_OUTPUT = 2'b10;

  // One extra bit lets size exceed the population range without truncating.
  localparam logic [pop_width:0] SIZE_EXT = (pop_width+1)'(size);

  state_t               r_state, w_state_next;
  logic [1:0]           r_mode, w_mode_next;
  logic [cnt_width-1:0] r_count, w_count_next;
  logic                 r_flag, w_flag_next;
  logic                 w_enabled;

  always_comb begin
    w_enabled = 1'b0;
    case (r_mode)
      MODE_SETUP:  w_enabled = ({1'b0, pop_in_data} >= SIZE_EXT);
      MODE_COMP:   w_enabled = 1'b1;
      MODE_OUTPUT: w_enabled = (free_out_fifo != '0);
      default:     w_enabled = 1'b0;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_mode_next  = r_mode;
    w_count_next = r_count;
    w_flag_next  = r_flag;
    case (r_state)
      IDLE: begin
        if (invoke_in) w_state_next = CHECK;
      end
      CHECK: begin
        if (w_enabled) begin
          w_state_next = FIRE;
        end else begin
          w_state_next = DONE;
          w_flag_next  = 1'b0;
        end
      end
      FIRE: begin
        w_state_next = WAIT;
      end
      WAIT: begin
        if (done_in) begin
          w_state_next = DONE;
          w_flag_next  = 1'b1;
        end
      end
      DONE: begin
        w_state_next = IDLE;
        // Mode rotation and the firing count commit together, only for real firings.
        if (r_flag) begin
          w_count_next = r_count + 1'b1;
          case (r_mode)
            MODE_SETUP:  w_mode_next = MODE_COMP;
            MODE_COMP:   w_mode_next = MODE_OUTPUT;
            default:     w_mode_next = MODE_SETUP;
          endcase
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_mode  <= MODE_SETUP;
      r_count <= '0;
      r_flag  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_mode  <= w_mode_next;
      r_count <= w_count_next;
      r_flag  <= w_flag_next;
    end
  end

  assign start_out       = (r_state == FIRE);
  assign invoke_done_out = (r_state == DONE);
  assign fired_out       = (r_state == DONE) && r_flag;
  assign next_mode_out   = r_mode;
  assign fire_count_out  = r_count;

endmodule

// File: tb/tb_window_invoke_scheduler.sv
// Bench for window_invoke_scheduler: directed scenarios plus random attempts
// compared against a mode/count reference model; a 4-bit-counter copy shows wrap.
module tb_window_invoke_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        invoke_in = 1'b0;
  logic [5:0]  pop_in_data = '0;
  logic [5:0]  free_out_fifo = '0;
  logic        done_in = 1'b0;
  logic        start_out, invoke_done_out, fired_out;
  logic [1:0]  next_mode_out;
  logic [15:0] fire_count_out;
  logic        s_start, s_done, s_fired;
  logic [1:0]  s_mode;
  logic [3:0]  s_count;

  int checks = 0;
  int errors = 0;
  int m_mode = 0;
  int m_count = 0;

  always #5 clk = ~clk;

  window_invoke_scheduler dut (
    .clk(clk), .rst(rst), .invoke_in(invoke_in), .pop_in_data(pop_in_data),
    .free_out_fifo(free_out_fifo), .done_in(done_in), .start_out(start_out),
    .next_mode_out(next_mode_out), .invoke_done_out(invoke_done_out),
    .fired_out(fired_out), .fire_count_out(fire_count_out)
  );

  window_invoke_scheduler #(.cnt_width(4)) dut_small (
    .clk(clk), .rst(rst), .invoke_in(invoke_in), .pop_in_data(pop_in_data),
    .free_out_fifo(free_out_fifo), .done_in(done_in), .start_out(s_start),
    .next_mode_out(s_mode), .invoke_done_out(s_done),
    .fired_out(s_fired), .fire_count_out(s_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit model_enabled(input int pop, input int free);
    if (m_mode == 0) return pop >= 3;
    if (m_mode == 1) return 1'b1;
    return free >= 1;
  endfunction

  task automatic chk_state(input string tag, input bit st, input bit dn, input bit fr);
    chk({tag, "_start"}, 32'(start_out), 32'(st));
    chk({tag, "_done"}, 32'(invoke_done_out), 32'(dn));
    chk({tag, "_fired"}, 32'(fired_out), 32'(fr));
    chk({tag, "_mode"}, 32'(next_mode_out), 32'(m_mode));
    chk({tag, "_count"}, 32'(fire_count_out), 32'(m_count & 16'hFFFF));
    chk({tag, "_count4"}, 32'(s_count), 32'(m_count & 15));
    chk({tag, "_sdone"}, 32'(s_done), 32'(dn));
  endtask

  task automatic attempt(input int pop, input int free, input int dly,
                         input bit hold, input bit early);
    bit en;
    en = model_enabled(pop, free);
    pop_in_data = 6'(pop);
    free_out_fifo = 6'(free);
    invoke_in = 1'b1;
    step();                                  // CHECK
    if (!hold) invoke_in = 1'b0;
    chk_state("check", 0, 0, 0);
    step();                                  // FIRE or DONE
    if (en) begin
      chk_state("fire", 1, 0, 0);
      if (early) done_in = 1'b1;
      step();                                // WAIT
      done_in = 1'b0;
      chk_state("wait", 0, 0, 0);
      for (int i = 0; i < dly; i++) begin
        step();
        chk_state("waitn", 0, 0, 0);
      end
      done_in = 1'b1;
      step();                                // DONE
      done_in = 1'b0;
      invoke_in = 1'b0;
      chk_state("done1", 0, 1, 1);
      step();
      m_mode = (m_mode + 1) % 3;
      m_count++;
      chk_state("idle1", 0, 0, 0);
    end else begin
      chk_state("done0", 0, 1, 0);
      invoke_in = 1'b0;
      step();
      chk_state("idle0", 0, 0, 0);
    end
    step();
    chk_state("idle", 0, 0, 0);
    $display("attempt pop=%0d free=%0d en=%0d mode=%0d count=%0d", pop, free, en, m_mode, m_count);
  endtask

  initial begin
    // Reset state
    #2;
    chk_state("reset", 0, 0, 0);
    step();
    step();
    rst = 1'b1;
    step();
    chk_state("post_reset", 0, 0, 0);

    // First SETUP_COMP firing with done four cycles after WAIT entry
    attempt(3, 0, 3, 0, 0);
    chk("first_mode", 32'(next_mode_out), 32'd1);
    chk("first_count", 32'(fire_count_out), 32'd1);

    // Reset and check SETUP_COMP not enabled with two tokens
    rst = 1'b0; #1; m_mode = 0; m_count = 0; step(); rst = 1'b1; step();
    attempt(2, 1, 0, 0, 0);
    chk("noen_mode", 32'(next_mode_out), 32'd0);
    chk("noen_count", 32'(fire_count_out), 32'd0);

    // Three firings rotate through all modes
    attempt(3, 1, 0, 0, 0);
    attempt(3, 1, 1, 0, 0);
    attempt(3, 1, 2, 0, 0);
    chk("rot_mode", 32'(next_mode_out), 32'd0);
    chk("rot_count", 32'(fire_count_out), 32'd3);

    // OUTPUT mode blocked by a full output FIFO, then released
    attempt(3, 1, 0, 0, 0);
    attempt(0, 0, 0, 0, 0);
    attempt(0, 0, 0, 0, 0);
    chk("out_blocked", 32'(next_mode_out), 32'd2);
    attempt(0, 1, 1, 0, 0);
    chk("out_fired", 32'(next_mode_out), 32'd0);

    // Held invoke and early done_in must not cause extra firings
    attempt(4, 1, 2, 1, 1);
    done_in = 1'b1; step(); done_in = 1'b0;
    chk_state("idle_done", 0, 0, 0);
    step();
    chk_state("idle_done2", 0, 0, 0);

    // Reset in WAIT abandons the firing; late done_in is ignored
    pop_in_data = 6'd5; free_out_fifo = 6'd1; invoke_in = 1'b1;
    step(); invoke_in = 1'b0; step(); step();
    chk("rw_in_wait", 32'(start_out), 32'd0);
    #2 rst = 1'b0;
    #1;
    m_mode = 0; m_count = 0;
    chk_state("rst_wait", 0, 0, 0);
    step();
    rst = 1'b1;
    done_in = 1'b1; step(); done_in = 1'b0;
    chk_state("late_done", 0, 0, 0);
    step();
    chk_state("late_done2", 0, 0, 0);

    // Random attempts against the model
    for (int n = 0; n < 40; n++) begin
      attempt(int'($urandom_range(0, 6)), int'($urandom_range(0, 2)),
              int'($urandom_range(0, 4)), ($urandom % 4) == 0, ($urandom % 4) == 0);
    end

    // Drive the 4-bit counter across its wrap point
    while ((m_count % 16) != 15) attempt(5, 1, 0, 0, 0);
    attempt(5, 1, 0, 0, 0);
    chk("wrap4", 32'(s_count), 32'd0);
    chk("wrap16", 32'(fire_count_out), 32'(m_count));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
